// File: rtl/vga_write_scheduler_pkg.sv
// Shared definitions for the VGA write scheduler: CPU port ids, FSM state
// encoding, status byte layout and a helper that packs the status byte.
package vga_write_scheduler_pkg;

    localparam logic [7:0] ADDR_PORT_ID = 8'd40;
    localparam logic [7:0] DATA_PORT_ID = 8'd41;
    localparam logic [7:0] STAT_PORT_ID = 8'd52;

    // Status byte layout: {overflow, full, empty, count[4:0]}
    localparam int ST_OVF_BIT   = 7;
    localparam int ST_FULL_BIT  = 6;
    localparam int ST_EMPTY_BIT = 5;

    typedef enum logic {
        S_WAIT  = 1'b0,
        S_DRAIN = 1'b1
    } wsched_state_t;

    function automatic logic [7:0] pack_status(input logic ovf, input logic full,
                                               input logic empty, input logic [4:0] cnt);
        logic [7:0] s;
        s = {3'b000, cnt};
        s[ST_OVF_BIT]   = ovf;
        s[ST_FULL_BIT]  = full;
        s[ST_EMPTY_BIT] = empty;
        return s;
    endfunction

endpackage

// File: rtl/vga_write_scheduler_if.sv
// Bus bundle between the PicoBlaze port decoder (CPU side) and the VGA
// pointer block (memory side). The scheduler uses the slave modport.
interface vga_write_scheduler_if;
    logic [7:0] Port_ID;
    logic [7:0] IN_DATA;
    logic       Write_Strobe;
    logic       Read_Strobe;
    logic [7:0] OUT_DATA;
    logic [7:0] MemAddr;
    logic [7:0] MemData;
    logic       Write;

    modport slave (
        input  Port_ID, IN_DATA, Write_Strobe, Read_Strobe,
        output OUT_DATA, MemAddr, MemData, Write
    );

    modport master (
        output Port_ID, IN_DATA, Write_Strobe, Read_Strobe,
        input  OUT_DATA, MemAddr, MemData, Write
    );
endinterface

// File: rtl/vga_write_scheduler_fifo.sv
// Synchronous FIFO holding {addr,data} write entries. A push into a full
// FIFO is accepted only when a pop happens in the same cycle; pops of an
// empty FIFO are ignored. Read data is the head entry, combinational.
module vga_wsched_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = 5,
    parameter int W     = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage array; no reset needed, contents are qualified by count.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/vga_write_scheduler.sv
// Tear-free write scheduler: buffers CPU (address,data) writes and commits
// them to display memory one per cycle, only while vertical blanking.
// Optional feature macro: VGA_WSCHED_FRAME_IRQ_EN (frame interrupt on the
// falling edge of VSync). Without it Irq is tied low.
module vga_write_scheduler
    import vga_write_scheduler_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter int         CW        = 5,
    parameter logic [7:0] ADDR_PORT = ADDR_PORT_ID,
    parameter logic [7:0] DATA_PORT = DATA_PORT_ID,
    parameter logic [7:0] STAT_PORT = STAT_PORT_ID
) (
    input  logic                  CLK,
    input  logic                  RESET,
    vga_write_scheduler_if.slave  bus,
    input  logic                  VSync,
    output logic                  Irq
);
    wsched_state_t state, state_nxt;

    logic          vblank;
    logic          wr_addr, wr_data, rd_stat;
    logic          pop, last_beat, ovf_set;
    logic [7:0]    addr_latch;
    logic          overflow;
    logic [15:0]   f_dout;
    logic          f_full, f_empty;
    logic [CW-1:0] f_count;
    logic [4:0]    cnt5;
    logic [7:0]    mem_addr_q, mem_data_q;
    logic          write_q;

    assign vblank  = ~VSync;
    assign wr_addr = bus.Write_Strobe && (bus.Port_ID == ADDR_PORT);
    assign wr_data = bus.Write_Strobe && (bus.Port_ID == DATA_PORT);
    assign rd_stat = bus.Read_Strobe  && (bus.Port_ID == STAT_PORT);
    // A dropped push is one that finds the FIFO full with no pop to make room.
    assign ovf_set = wr_data && f_full && !pop;

    vga_wsched_fifo #(.DEPTH(DEPTH), .CW(CW), .W(16)) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (wr_data),
        .pop   (pop),
        .din   ({addr_latch, bus.IN_DATA}),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    // Address latch: loaded by the address port, auto-increments on every data write.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)        addr_latch <= 8'h00;
        else if (wr_addr) addr_latch <= bus.IN_DATA;
        else if (wr_data) addr_latch <= addr_latch + 8'h01;
    end

    // Sticky overflow flag; a fresh overflow beats a same-cycle status read.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)        overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
        else if (rd_stat) overflow <= 1'b0;
    end

    // Status byte is combinational on the status port, zero on any other port.
    assign cnt5         = 5'(f_count);
    assign bus.OUT_DATA = (bus.Port_ID == STAT_PORT) ?
                          pack_status(overflow, f_full, f_empty, cnt5) : 8'h00;

    // This pop empties the FIFO unless a push lands in the same cycle.
    assign last_beat = f_empty || ((f_count == CW'(1)) && !wr_data);

    // FSM state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_WAIT;
        else       state <= state_nxt;
    end

    // FSM next state and pop decision; pops stop the moment vblank ends.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_WAIT: begin
                if (vblank && !f_empty) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                pop = vblank && !f_empty;
                if (!vblank || last_beat) state_nxt = S_WAIT;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    // Registered memory port: one write beat on the edge after each pop, values hold otherwise.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem_addr_q <= 8'h00;
            mem_data_q <= 8'h00;
            write_q    <= 1'b0;
        end else begin
            write_q <= pop;
            if (pop) begin
                mem_addr_q <= f_dout[15:8];
                mem_data_q <= f_dout[7:0];
            end
        end
    end

    assign bus.MemAddr = mem_addr_q;
    assign bus.MemData = mem_data_q;
    assign bus.Write   = write_q;

`ifdef VGA_WSCHED_FRAME_IRQ_EN
    logic vsync_q, irq_q;

    // Frame interrupt: one-cycle pulse when VSync falls (start of vblank).
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vsync_q <= 1'b1;
            irq_q   <= 1'b0;
        end else begin
            vsync_q <= VSync;
            irq_q   <= vsync_q & ~VSync;
        end
    end

    assign Irq = irq_q;
`else
    assign Irq = 1'b0;
`endif
endmodule

// File: tb/tb_vga_write_scheduler.sv
// Directed bench for vga_write_scheduler. Inputs change on the falling clock
// edge; outputs are sampled on the falling edge (or just after an async reset).
module tb_vga_write_scheduler;
    logic CLK = 1'b0;
    logic RESET;
    logic VSync;
    logic Irq;
    int   checks   = 0;
    int   failures = 0;

    vga_write_scheduler_if bus();

    vga_write_scheduler dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus),
        .VSync (VSync),
        .Irq   (Irq)
    );

    always #5 CLK = ~CLK;

    task automatic do_reset();
        RESET = 1'b1;
        bus.Write_Strobe = 1'b0;
        bus.Read_Strobe  = 1'b0;
        bus.Port_ID      = 8'd52;
        bus.IN_DATA      = 8'h00;
        VSync = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] port, input logic [7:0] d);
        bus.Port_ID = port;
        bus.IN_DATA = d;
        bus.Write_Strobe = 1'b1;
        @(negedge CLK);
        bus.Write_Strobe = 1'b0;
        bus.Port_ID = 8'd52;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.OUT_DATA !== 8'h20) begin failures++; $display("FAIL reset_status got=%h exp=20", bus.OUT_DATA); end
        checks++; if (bus.Write !== 1'b0) begin failures++; $display("FAIL reset_write got=%b exp=0", bus.Write); end
        checks++; if ({bus.MemAddr, bus.MemData} !== 16'h0000) begin failures++; $display("FAIL reset_mem got=%h exp=0000", {bus.MemAddr, bus.MemData}); end
        checks++; if (Irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", Irq); end
    endtask

    // Writes outside vblank only queue; nothing reaches memory.
    task automatic test_queue();
        cpu_write(8'd40, 8'h10);
        cpu_write(8'd41, 8'hAA);
        cpu_write(8'd41, 8'hBB);
        #1;
        checks++; if (bus.Write !== 1'b0) begin failures++; $display("FAIL queue_write got=%b exp=0", bus.Write); end
        checks++; if (bus.OUT_DATA !== 8'h02) begin failures++; $display("FAIL queue_status got=%h exp=02", bus.OUT_DATA); end
        bus.Port_ID = 8'd40;
        #1;
        checks++; if (bus.OUT_DATA !== 8'h00) begin failures++; $display("FAIL other_port_status got=%h exp=00", bus.OUT_DATA); end
        bus.Port_ID = 8'd52;
    endtask

    // Entering vblank: one idle edge, then one commit per cycle in push order.
    task automatic test_drain();
        VSync = 1'b0;
        @(negedge CLK);
        checks++; if (bus.Write !== 1'b0) begin failures++; $display("FAIL drain_first_edge got=%b exp=0", bus.Write); end
        @(negedge CLK);
        checks++; if ({bus.Write, bus.MemAddr, bus.MemData} !== {1'b1, 8'h10, 8'hAA}) begin failures++; $display("FAIL drain_beat0 got=%b/%h/%h exp=1/10/AA", bus.Write, bus.MemAddr, bus.MemData); end
        @(negedge CLK);
        checks++; if ({bus.Write, bus.MemAddr, bus.MemData} !== {1'b1, 8'h11, 8'hBB}) begin failures++; $display("FAIL drain_beat1 got=%b/%h/%h exp=1/11/BB", bus.Write, bus.MemAddr, bus.MemData); end
        @(negedge CLK);
        #1;
        checks++; if (bus.Write !== 1'b0) begin failures++; $display("FAIL drain_done_write got=%b exp=0", bus.Write); end
        checks++; if (bus.OUT_DATA !== 8'h20) begin failures++; $display("FAIL drain_done_status got=%h exp=20", bus.OUT_DATA); end
        VSync = 1'b1;
        @(negedge CLK);
    endtask

    // 17 pushes into a 16-deep FIFO: one dropped, sticky overflow until read.
    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) cpu_write(8'd41, 8'(i));
        #1;
        checks++; if (bus.OUT_DATA !== 8'hD0) begin failures++; $display("FAIL ovf_status got=%h exp=D0", bus.OUT_DATA); end
        bus.Read_Strobe = 1'b1;
        @(negedge CLK);
        bus.Read_Strobe = 1'b0;
        #1;
        checks++; if (bus.OUT_DATA !== 8'h50) begin failures++; $display("FAIL ovf_cleared got=%h exp=50", bus.OUT_DATA); end
    endtask

    // 8 entries from 0xFE (latch wraps); a short vblank commits 3, the rest commit next vblank.
    task automatic test_partial_drain();
        logic [7:0] ea [5];
        logic [7:0] ed [5];
        ea = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        ed = '{8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
        do_reset();
        cpu_write(8'd40, 8'hFE);
        for (int i = 0; i < 8; i++) cpu_write(8'd41, 8'h30 + 8'(i));
        VSync = 1'b0;
        @(negedge CLK);
        checks++; if (bus.Write !== 1'b0) begin failures++; $display("FAIL part_first_edge got=%b exp=0", bus.Write); end
        @(negedge CLK);
        checks++; if ({bus.Write, bus.MemAddr, bus.MemData} !== {1'b1, 8'hFE, 8'h30}) begin failures++; $display("FAIL part_beat0 got=%b/%h/%h exp=1/FE/30", bus.Write, bus.MemAddr, bus.MemData); end
        @(negedge CLK);
        checks++; if ({bus.Write, bus.MemAddr, bus.MemData} !== {1'b1, 8'hFF, 8'h31}) begin failures++; $display("FAIL part_beat1 got=%b/%h/%h exp=1/FF/31", bus.Write, bus.MemAddr, bus.MemData); end
        @(negedge CLK);
        checks++; if ({bus.Write, bus.MemAddr, bus.MemData} !== {1'b1, 8'h00, 8'h32}) begin failures++; $display("FAIL part_beat2 got=%b/%h/%h exp=1/00/32", bus.Write, bus.MemAddr, bus.MemData); end
        VSync = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        checks++; if ({bus.Write, bus.MemAddr, bus.MemData} !== {1'b0, 8'h00, 8'h32}) begin failures++; $display("FAIL part_hold got=%b/%h/%h exp=0/00/32", bus.Write, bus.MemAddr, bus.MemData); end
        checks++; if (bus.OUT_DATA !== 8'h05) begin failures++; $display("FAIL part_status got=%h exp=05", bus.OUT_DATA); end
        VSync = 1'b0;
        @(negedge CLK);
        checks++; if (bus.Write !== 1'b0) begin failures++; $display("FAIL part2_first_edge got=%b exp=0", bus.Write); end
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            checks++; if ({bus.Write, bus.MemAddr, bus.MemData} !== {1'b1, ea[k], ed[k]}) begin failures++; $display("FAIL part2_beat%0d got=%b/%h/%h exp=1/%h/%h", k, bus.Write, bus.MemAddr, bus.MemData, ea[k], ed[k]); end
        end
        @(negedge CLK);
        #1;
        checks++; if (bus.Write !== 1'b0) begin failures++; $display("FAIL part2_done got=%b exp=0", bus.Write); end
        checks++; if (bus.OUT_DATA !== 8'h20) begin failures++; $display("FAIL part2_status got=%h exp=20", bus.OUT_DATA); end
        VSync = 1'b1;
        @(negedge CLK);
    endtask

    // Full FIFO draining with a push in the same cycle: accepted, no overflow.
    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 16; i++) cpu_write(8'd41, 8'(i));
        #1;
        checks++; if (bus.OUT_DATA !== 8'h50) begin failures++; $display("FAIL full_status got=%h exp=50", bus.OUT_DATA); end
        VSync = 1'b0;
        @(negedge CLK);
        cpu_write(8'd41, 8'hEE);
        checks++; if ({bus.Write, bus.MemAddr, bus.MemData} !== {1'b1, 8'h00, 8'h00}) begin failures++; $display("FAIL full_pp_beat got=%b/%h/%h exp=1/00/00", bus.Write, bus.MemAddr, bus.MemData); end
        VSync = 1'b1;
        @(negedge CLK);
        #1;
        checks++; if (bus.OUT_DATA !== 8'h50) begin failures++; $display("FAIL full_pp_status got=%h exp=50", bus.OUT_DATA); end
    endtask

    // Async reset while commits are streaming: outputs clear without a clock edge.
    task automatic test_reset_mid_drain();
        VSync = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (bus.Write !== 1'b1) begin failures++; $display("FAIL mid_drain_active got=%b exp=1", bus.Write); end
        #2;
        RESET = 1'b1;
        #1;
        checks++; if (bus.Write !== 1'b0) begin failures++; $display("FAIL mid_reset_write got=%b exp=0", bus.Write); end
        checks++; if (bus.OUT_DATA !== 8'h20) begin failures++; $display("FAIL mid_reset_status got=%h exp=20", bus.OUT_DATA); end
        @(negedge CLK);
        RESET = 1'b0;
        VSync = 1'b1;
        @(negedge CLK);
    endtask

    // Frame interrupt follows each VSync fall (tied low when the feature is off).
    task automatic test_irq();
        VSync = 1'b0;
        @(negedge CLK);
`ifdef VGA_WSCHED_FRAME_IRQ_EN
        checks++; if (Irq !== 1'b1) begin failures++; $display("FAIL irq_pulse got=%b exp=1", Irq); end
`else
        checks++; if (Irq !== 1'b0) begin failures++; $display("FAIL irq_tied got=%b exp=0", Irq); end
`endif
        @(negedge CLK);
        checks++; if (Irq !== 1'b0) begin failures++; $display("FAIL irq_one_cycle got=%b exp=0", Irq); end
        VSync = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b1;
        VSync = 1'b1;
        bus.Port_ID = 8'd52;
        bus.IN_DATA = 8'h00;
        bus.Write_Strobe = 1'b0;
        bus.Read_Strobe  = 1'b0;
        @(negedge CLK);
        test_reset();
        test_queue();
        test_drain();
        test_overflow();
        test_partial_drain();
        test_full_push_pop();
        test_reset_mid_drain();
        test_irq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
